// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles, branch squashes,
// data-memory freezes with timeout, debug halt/drain/resume and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             dbg_halt_req,
    input  logic             dbg_resume,
    input  logic             stat_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state_dbg
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    localparam logic [WCW-1:0]   TIMEOUT_V = WCW'(MEM_TIMEOUT);
    localparam logic [2:0]       DRAIN_LAST = 3'd3;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state_r;
    logic [WCW-1:0]   wait_cnt_r;
    logic [2:0]       drain_cnt_r;
    logic             origin_drain_r;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic [1:0]       state_nxt_s;
    logic [WCW-1:0]   wait_cnt_nxt_s;
    logic [2:0]       drain_cnt_nxt_s;
    logic             origin_drain_nxt_s;
    logic             err_set_s;

    logic             lu_s;
    logic             freeze_raw_s;
    logic             timeout_s;
    logic             release_s;
    logic             freeze_s;
    logic             decode_active_s;
    logic             drain_mode_s;
    logic             drain_adv_s;
    logic             stall_inc_s;

    logic             pc_en_s;
    logic             if_id_en_s;
    logic             id_ex_en_s;
    logic             ex_mem_en_s;
    logic             mem_wb_en_s;
    logic             if_id_flush_s;
    logic             id_ex_flush_s;

    function automatic logic load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2,
        input logic [4:0] rd,
        input logic       is_load
    );
        return is_load & (rd != 5'd0) & ((use1 & (rs1 == rd)) | (use2 & (rs2 == rd)));
    endfunction

    // Hazard terms and the freeze/release qualification of the current cycle
    always_comb begin
        lu_s         = load_use(id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read);
        freeze_raw_s = mem_req & ~mem_ready;
        timeout_s    = (state_r == ST_MEM_WAIT) & (wait_cnt_r == TIMEOUT_V);
        release_s    = (state_r == ST_MEM_WAIT) & (~freeze_raw_s | timeout_s);
        case (state_r)
            ST_RUN:      freeze_s = freeze_raw_s;
            ST_DRAIN:    freeze_s = freeze_raw_s;
            ST_MEM_WAIT: freeze_s = ~release_s;
            ST_HALTED:   freeze_s = 1'b0;
            default:     freeze_s = 1'b0;
        endcase
        decode_active_s = (state_r != ST_HALTED) & ~freeze_s;
        // A release that lands in DRAIN behaves as a drain cycle so the PC stays put
        drain_mode_s = (state_r == ST_DRAIN) |
                       (release_s & (origin_drain_r | dbg_halt_req));
    end

    // Enable/flush decode: branch > load-use > normal, with the drain override on top
    always_comb begin
        pc_en_s       = 1'b0;
        if_id_en_s    = 1'b0;
        id_ex_en_s    = 1'b0;
        ex_mem_en_s   = 1'b0;
        mem_wb_en_s   = 1'b0;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        if (decode_active_s) begin
            id_ex_en_s  = 1'b1;
            ex_mem_en_s = 1'b1;
            mem_wb_en_s = 1'b1;
            if (ex_branch_taken) begin
                pc_en_s       = 1'b1;
                if_id_en_s    = 1'b1;
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
            end else if (lu_s) begin
                pc_en_s       = 1'b0;
                if_id_en_s    = 1'b0;
                id_ex_flush_s = 1'b1;
            end else begin
                pc_en_s    = 1'b1;
                if_id_en_s = 1'b1;
            end
            if (drain_mode_s) begin
                pc_en_s       = ex_branch_taken;
                if_id_flush_s = if_id_en_s;
            end else begin
                pc_en_s = pc_en_s;
            end
        end else begin
            pc_en_s = 1'b0;
        end
    end

    assign pc_en        = rst_n & pc_en_s;
    assign if_id_en     = rst_n & if_id_en_s;
    assign id_ex_en     = rst_n & id_ex_en_s;
    assign ex_mem_en    = rst_n & ex_mem_en_s;
    assign mem_wb_en    = rst_n & mem_wb_en_s;
    assign if_id_flush  = rst_n & if_id_flush_s;
    assign id_ex_flush  = rst_n & id_ex_flush_s;
    assign halted       = (state_r == ST_HALTED);
    assign mem_err      = mem_err_r;
    assign stall_cycles = stall_cnt_r;
    assign state_dbg    = state_r;

    assign drain_adv_s = drain_mode_s & decode_active_s & if_id_en_s;
    assign stall_inc_s = (state_r != ST_HALTED) &
                         (freeze_s | (decode_active_s & ~ex_branch_taken & lu_s));

    // Sequencer next-state and counter updates
    always_comb begin
        state_nxt_s        = state_r;
        wait_cnt_nxt_s     = wait_cnt_r;
        drain_cnt_nxt_s    = drain_cnt_r;
        origin_drain_nxt_s = origin_drain_r;
        err_set_s          = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (freeze_raw_s) begin
                    state_nxt_s        = ST_MEM_WAIT;
                    wait_cnt_nxt_s     = WCW'(1);
                    origin_drain_nxt_s = 1'b0;
                    drain_cnt_nxt_s    = 3'd0;
                end else if (dbg_halt_req) begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (freeze_raw_s) begin
                    state_nxt_s        = ST_MEM_WAIT;
                    wait_cnt_nxt_s     = WCW'(1);
                    origin_drain_nxt_s = 1'b1;
                end else if (drain_adv_s) begin
                    drain_cnt_nxt_s = drain_cnt_r + 3'd1;
                    state_nxt_s     = (drain_cnt_r == DRAIN_LAST) ? ST_HALTED : ST_DRAIN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                if (release_s) begin
                    err_set_s      = timeout_s & freeze_raw_s;
                    wait_cnt_nxt_s = {WCW{1'b0}};
                    if (origin_drain_r | dbg_halt_req) begin
                        if (drain_adv_s) begin
                            drain_cnt_nxt_s = drain_cnt_r + 3'd1;
                            state_nxt_s     = (drain_cnt_r == DRAIN_LAST) ? ST_HALTED : ST_DRAIN;
                        end else begin
                            state_nxt_s = ST_DRAIN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WCW'(1);
                end
            end
            ST_HALTED: begin
                if (dbg_resume) begin
                    state_nxt_s        = ST_RUN;
                    drain_cnt_nxt_s    = 3'd0;
                    origin_drain_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s        = ST_RUN;
                wait_cnt_nxt_s     = {WCW{1'b0}};
                drain_cnt_nxt_s    = 3'd0;
                origin_drain_nxt_s = 1'b0;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RUN;
            wait_cnt_r     <= {WCW{1'b0}};
            drain_cnt_r    <= 3'd0;
            origin_drain_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            wait_cnt_r     <= wait_cnt_nxt_s;
            drain_cnt_r    <= drain_cnt_nxt_s;
            origin_drain_r <= origin_drain_nxt_s;
        end
    end

    // Sticky memory-timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err_r <= 1'b0;
        end else if (err_set_s) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stat_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       mem_req, mem_ready, dbg_halt_req, dbg_resume, stat_clr;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, halted, mem_err;
    logic [3:0] stall_cycles;
    logic [1:0] state_dbg;

    typedef struct {
        string      nm;
        logic [4:0] en;
        logic [1:0] fl;
        logic       h;
        logic       e;
        logic [1:0] st;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   fails     = 0;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00111;
    localparam logic [4:0] EN_DRN  = 5'b01111;
    localparam logic [1:0] FL_NONE = 2'b00;
    localparam logic [1:0] FL_LU   = 2'b01;
    localparam logic [1:0] FL_DRN  = 2'b10;
    localparam logic [1:0] FL_BR   = 2'b11;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume), .stat_clr(stat_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halted(halted), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Monitor: outputs settle mid-cycle; compare against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [4:0] a_en;
            logic [1:0] a_fl;
            x    = exp_q.pop_front();
            a_en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
            a_fl = {if_id_flush, id_ex_flush};
            tests_run++;
            if ({a_en, a_fl, halted, mem_err, state_dbg, stall_cycles} !==
                {x.en, x.fl, x.h, x.e, x.st, x.cnt}) begin
                fails++;
                $display("FAIL %s: got en=%b fl=%b halted=%b err=%b st=%0d cnt=%0d, expected en=%b fl=%b halted=%b err=%b st=%0d cnt=%0d",
                         x.nm, a_en, a_fl, halted, mem_err, state_dbg, stall_cycles,
                         x.en, x.fl, x.h, x.e, x.st, x.cnt);
            end
        end
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        dbg_halt_req = 1'b0; dbg_resume = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic lu_in(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1'b1;
    endtask

    // Inputs for this cycle are already applied; queue its expectation and advance one cycle
    task automatic cyc(input string nm, input logic [4:0] en, input logic [1:0] fl,
                       input logic h, input logic e, input logic [1:0] st, input logic [3:0] cnt);
        exp_t x;
        x.nm = nm; x.en = en; x.fl = fl; x.h = h; x.e = e; x.st = st; x.cnt = cnt;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", EN_NONE, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);
        rst_n = 1'b1;
        cyc("run_idle", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);

        lu_in(5'd5);
        cyc("lu_rs2", EN_LU, FL_LU, 1'b0, 1'b0, 2'd0, 4'd0);
        cyc("after_lu", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd1);
        lu_in(5'd0);
        cyc("lu_x0", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd1);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
        cyc("lu_rs1", EN_LU, FL_LU, 1'b0, 1'b0, 2'd0, 4'd1);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
        cyc("lu_unused", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd2);
        lu_in(5'd5); ex_branch_taken = 1'b1;
        cyc("branch_lu", EN_ALL, FL_BR, 1'b0, 1'b0, 2'd0, 4'd2);
        cyc("after_br", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd2);

        mem_req = 1'b1; ex_branch_taken = 1'b1;
        cyc("frz_br", EN_NONE, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd2);
        mem_req = 1'b1;
        cyc("frz2", EN_NONE, FL_NONE, 1'b0, 1'b0, 2'd1, 4'd3);
        mem_req = 1'b1;
        cyc("frz3", EN_NONE, FL_NONE, 1'b0, 1'b0, 2'd1, 4'd4);
        mem_req = 1'b1; mem_ready = 1'b1;
        cyc("mem_rel", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd1, 4'd5);
        cyc("mem_done", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd5);

        stat_clr = 1'b1; lu_in(5'd4);
        cyc("clr_lu", EN_LU, FL_LU, 1'b0, 1'b0, 2'd0, 4'd5);
        cyc("cleared", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);
        mem_req = 1'b1; mem_ready = 1'b1;
        cyc("mem_fast", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);

        mem_req = 1'b1;
        cyc("to_frz1", EN_NONE, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);
        for (int i = 1; i < 4; i++) begin
            mem_req = 1'b1;
            cyc("to_frz", EN_NONE, FL_NONE, 1'b0, 1'b0, 2'd1, 4'(i));
        end
        mem_req = 1'b1;
        cyc("to_rel", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd1, 4'd4);
        cyc("to_err", EN_ALL, FL_NONE, 1'b0, 1'b1, 2'd0, 4'd4);

        dbg_halt_req = 1'b1;
        cyc("halt_req", EN_ALL, FL_NONE, 1'b0, 1'b1, 2'd0, 4'd4);
        for (int i = 0; i < 4; i++) begin
            dbg_halt_req = 1'b1;
            cyc("drain", EN_DRN, FL_DRN, 1'b0, 1'b1, 2'd2, 4'd4);
        end
        dbg_halt_req = 1'b1;
        cyc("halted", EN_NONE, FL_NONE, 1'b1, 1'b1, 2'd3, 4'd4);
        lu_in(5'd6);
        cyc("halted_lu", EN_NONE, FL_NONE, 1'b1, 1'b1, 2'd3, 4'd4);
        dbg_resume = 1'b1;
        cyc("resume", EN_NONE, FL_NONE, 1'b1, 1'b1, 2'd3, 4'd4);
        cyc("resumed", EN_ALL, FL_NONE, 1'b0, 1'b1, 2'd0, 4'd4);

        dbg_halt_req = 1'b1;
        cyc("halt2_req", EN_ALL, FL_NONE, 1'b0, 1'b1, 2'd0, 4'd4);
        dbg_halt_req = 1'b1;
        cyc("drain2_a", EN_DRN, FL_DRN, 1'b0, 1'b1, 2'd2, 4'd4);
        dbg_halt_req = 1'b1; mem_req = 1'b1;
        cyc("drain2_frz", EN_NONE, FL_NONE, 1'b0, 1'b1, 2'd2, 4'd4);
        dbg_halt_req = 1'b1; mem_req = 1'b1;
        cyc("drain2_wait", EN_NONE, FL_NONE, 1'b0, 1'b1, 2'd1, 4'd5);
        dbg_halt_req = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
        cyc("drain2_rel", EN_DRN, FL_DRN, 1'b0, 1'b1, 2'd1, 4'd6);
        dbg_halt_req = 1'b1; lu_in(5'd8);
        cyc("drain2_lu", EN_LU, FL_LU, 1'b0, 1'b1, 2'd2, 4'd6);
        dbg_halt_req = 1'b1;
        cyc("drain2_c", EN_DRN, FL_DRN, 1'b0, 1'b1, 2'd2, 4'd7);
        dbg_halt_req = 1'b1;
        cyc("drain2_d", EN_DRN, FL_DRN, 1'b0, 1'b1, 2'd2, 4'd7);
        cyc("halted2", EN_NONE, FL_NONE, 1'b1, 1'b1, 2'd3, 4'd7);
        dbg_resume = 1'b1;
        cyc("resume2", EN_NONE, FL_NONE, 1'b1, 1'b1, 2'd3, 4'd7);
        cyc("resumed2", EN_ALL, FL_NONE, 1'b0, 1'b1, 2'd0, 4'd7);

        mem_req = 1'b1;
        cyc("rst_frz", EN_NONE, FL_NONE, 1'b0, 1'b1, 2'd0, 4'd7);
        mem_req = 1'b1;
        cyc("rst_wait", EN_NONE, FL_NONE, 1'b0, 1'b1, 2'd1, 4'd8);
        rst_n = 1'b0; mem_req = 1'b1;
        cyc("rst_mid", EN_NONE, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);
        rst_n = 1'b1;
        cyc("rst_after", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);

        for (int i = 0; i < 20; i++) begin
            lu_in(5'd9);
            cyc("sat_lu", EN_LU, FL_LU, 1'b0, 1'b0, 2'd0, (i > 15) ? 4'd15 : 4'(i));
        end
        cyc("sat_hold", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd15);
        stat_clr = 1'b1;
        cyc("sat_clr", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd15);
        cyc("sat_zero", EN_ALL, FL_NONE, 1'b0, 1'b0, 2'd0, 4'd0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
